// File: rtl/shift_sequencer.sv
// Multi-cycle shifter/rotator: moves the operand at most MAX_SHIFT_MAG bits per clock.
// Optional rotate support is built when SHIFT_SEQ_ROTATE_EN is defined; otherwise all shifts are logical.
module shift_sequencer #(
   parameter int LEN           = 8,
   parameter int MAX_SHIFT_MAG = 2,
   localparam int AMT_W        = $clog2(LEN)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:LEN-1]   in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic             in_dir,
   input  logic             in_rot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [0:LEN-1]   out_data,
   output logic             busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(MAX_SHIFT_MAG);
   localparam logic [AMT_W:0]   LEN_W   = (AMT_W+1)'(LEN);

   logic [1:0]       state_q, state_d;
   logic [0:LEN-1]   data_q, data_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic             dir_q, dir_d;
`ifdef SHIFT_SEQ_ROTATE_EN
   logic             rot_q, rot_d;
   logic [AMT_W:0]   back;
   logic [0:LEN-1]   wrapped;
`else
   logic             unused_rot;
`endif
   logic             accept;
   logic [AMT_W-1:0] step;
   logic [0:LEN-1]   shifted;

   assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_SHIFT);
   assign out_data  = data_q;
   assign accept    = in_valid & in_ready;

`ifndef SHIFT_SEQ_ROTATE_EN
   assign unused_rot = in_rot;
`endif

   // Bit 0 is the MSB, so '<<' moves data toward bit 0 (left).
   always_comb begin
      step    = (rem_q > MAX_AMT) ? MAX_AMT : rem_q;
      shifted = dir_q ? (data_q >> step) : (data_q << step);
`ifdef SHIFT_SEQ_ROTATE_EN
      back    = LEN_W - {1'b0, step};
      wrapped = dir_q ? (data_q << back) : (data_q >> back);
      if (rot_q) begin
         shifted = shifted | wrapped;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_d   = rot_q;
`endif
      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
         end
         S_SHIFT: begin
            data_d = shifted;
            rem_d  = rem_q - step;
            if (rem_q <= MAX_AMT) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Acceptance from DONE overrides the return to IDLE, giving back-to-back operation.
      if (accept) begin
         data_d  = in_data;
         rem_d   = in_amt;
         dir_d   = in_dir;
`ifdef SHIFT_SEQ_ROTATE_EN
         rot_d   = in_rot;
`endif
         state_d = (in_amt == '0) ? S_DONE : S_SHIFT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
         rot_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
`ifdef SHIFT_SEQ_ROTATE_EN
         rot_q   <= rot_d;
`endif
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer (LEN=8, MAX_SHIFT_MAG=2) using directed vectors.
module tb_shift_sequencer;

   localparam int LEN = 8;
   localparam int MAX = 2;
`ifdef SHIFT_SEQ_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   typedef struct {
      logic [7:0] d;
      int         acc;
      int         n;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [0:LEN-1] in_data = '0;
   logic [2:0]     in_amt = '0;
   logic           in_dir = 1'b0;
   logic           in_rot = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [0:LEN-1] out_data;
   logic           busy;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t q[$];

   shift_sequencer #(.LEN(LEN), .MAX_SHIFT_MAG(MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_amt(in_amt), .in_dir(in_dir), .in_rot(in_rot),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per new result, then checks it holds until consumed.
   logic [7:0] held;
   bit         seen = 1'b0;
   int         busy_cnt = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         seen = 1'b0;
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (out_valid) begin
            if (!seen) begin
               if (q.size() == 0) begin
                  chk("unexpected_valid", 32'(out_valid), 32'd0);
               end else begin
                  e = q.pop_front();
                  chk("data", 32'(out_data), 32'(e.d));
                  chk("latency", 32'(cyc - e.acc), 32'(e.n));
                  chk("busy_cycles", 32'(busy_cnt), 32'(e.n));
               end
               held = out_data;
               seen = 1'b1;
            end else begin
               chk("hold_data", 32'(out_data), 32'(held));
            end
            if (out_ready) begin
               seen = 1'b0;
               busy_cnt = 0;
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, input int amt, input bit dir, input bit rot,
                       input logic [7:0] exp);
      bit   got = 1'b0;
      exp_t e;
      @(posedge clk) #1;
      in_data  = d;
      in_amt   = 3'(amt);
      in_dir   = dir;
      in_rot   = rot;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (in_ready) begin
            e.d   = exp;
            e.acc = cyc + 1;
            e.n   = (amt + MAX - 1) / MAX;
            q.push_back(e);
            got = 1'b1;
         end
      end
      if (!got) chk("accept_timeout", 32'(got), 32'd1);
      @(posedge clk) #1;
      in_valid = 1'b0;
      in_data  = ~d;
      in_amt   = 3'(amt + 3);
      in_dir   = ~dir;
      in_rot   = ~rot;
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !out_valid) done = 1'b1;
      end
      if (!done) chk("drain_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      @(posedge clk) #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      send(8'h81, 3, 1'b0, 1'b0, 8'h08); drain();
      send(8'h81, 3, 1'b1, 1'b0, 8'h10); drain();
      send(8'h81, 3, 1'b0, 1'b1, ROT ? 8'h0C : 8'h08); drain();
      send(8'hA5, 0, 1'b0, 1'b0, 8'hA5); drain();
      send(8'h81, 7, 1'b0, 1'b0, 8'h80); drain();
      send(8'h81, 7, 1'b1, 1'b1, ROT ? 8'h03 : 8'h01); drain();
      send(8'hB4, 1, 1'b1, 1'b0, 8'h5A); drain();
      send(8'hB4, 5, 1'b0, 1'b1, ROT ? 8'h96 : 8'h80); drain();
      send(8'hFF, 6, 1'b0, 1'b0, 8'hC0); drain();

      // Stall in DONE, then hand off back-to-back.
      out_ready = 1'b0;
      send(8'h81, 2, 1'b0, 1'b0, 8'h04);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_valid_hold", 32'(out_valid), 32'd1);
      end
      @(posedge clk) #1 out_ready = 1'b1;
      send(8'h0F, 3, 1'b1, 1'b0, 8'h01);
      @(negedge clk);
      chk("b2b_busy", 32'(busy), 32'd1);
      drain();

      // Reset mid-SHIFT discards the operation.
      send(8'h81, 7, 1'b0, 1'b0, 8'h80);
      @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      q.delete();
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_out_data", 32'(out_data), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_abort_valid", 32'(out_valid), 32'd0);

      send(8'h81, 3, 1'b0, 1'b0, 8'h08); drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter LEN, default 8, data width in bits; SHALL be at least 2.
REQ-002 Parameter MAX_SHIFT_MAG, default 2, max shift distance per clock; SHALL be in 1..LEN-1.
REQ-003 Local width AMT_W = $clog2(LEN) SHALL size the amount port.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  request accepted on an edge where in_valid&in_ready.
REQ-008 in_data  input  [0:LEN-1]  operand; bit 0 is MSB.
REQ-009 in_amt  input  AMT_W  total shift distance, 0..LEN-1.
REQ-010 in_dir  input  1  0 = left (toward bit 0), 1 = right (toward bit LEN-1).
REQ-011 in_rot  input  1  1 = rotate, 0 = logical zero-fill.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  result consumed on an edge where out_valid&out_ready.
REQ-014 out_data  output  [0:LEN-1]  shifted result.
REQ-015 busy  output  1  high in SHIFT state.

Function
REQ-016 States SHALL be IDLE, SHIFT, DONE, encoded in one registered state variable.
REQ-017 in_ready SHALL equal (state==IDLE) | (state==DONE & out_ready); out_valid SHALL equal (state==DONE).
REQ-018 On acceptance, in_data, in_amt, in_dir, in_rot SHALL be registered; inputs are ignored at all other times.
REQ-019 On acceptance with in_amt==0, next state SHALL be DONE with data unchanged.
REQ-020 On acceptance with in_amt>0, next state SHALL be SHIFT with remaining count rem=in_amt.
REQ-021 In SHIFT, each edge SHALL shift the data register by step=min(rem,MAX_SHIFT_MAG) in the stored direction and set rem=rem-step.
REQ-022 In SHIFT, when rem<=MAX_SHIFT_MAG the step SHALL be final and next state SHALL be DONE.
REQ-023 Latency: out_valid SHALL first be high in the cycle after edge N=ceil(in_amt/MAX_SHIFT_MAG) counted from the acceptance edge (N=0 for in_amt 0).
REQ-024 Logical shift SHALL fill vacated positions with 0; rotate SHALL wrap bits end-around.
REQ-025 In DONE, out_data and out_valid SHALL hold stable until out_ready.
REQ-026 In DONE with out_ready and in_valid on the same edge, the new request SHALL be accepted (back-to-back, no IDLE bubble).
REQ-027 In DONE with out_ready and no in_valid, next state SHALL be IDLE.
REQ-028 out_data SHALL reflect the data register in every state; it is defined only while out_valid.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE, data=0, rem=0, direction=0, rotate=0, regardless of clock.
REQ-030 During and after reset: in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-031 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; no result is produced.

Configuration
REQ-032 Macro SHIFT_SEQ_ROTATE_EN defined: in_rot SHALL select rotate per REQ-024.
REQ-033 Macro SHIFT_SEQ_ROTATE_EN undefined: in_rot SHALL be ignored, no rotate register or logic exists, all shifts logical.

Verification
REQ-034 LEN=8, MAX=2: in 8'h81, amt 3, left, logical -> out_data 8'h08, out_valid 2 edges after accept.
REQ-035 in 8'h81, amt 3, right, logical -> 8'h10; busy high for exactly 2 cycles.
REQ-036 With SHIFT_SEQ_ROTATE_EN: in 8'h81, amt 3, left, rot -> 8'h0C; undefined macro -> 8'h08.
REQ-037 amt 0 -> out_valid cycle after accept, out_data=in_data; amt 7 -> out_valid after 4 edges.
REQ-038 out_ready held low 5 cycles in DONE -> out_data stable, in_ready low; then out_ready&in_valid same edge -> next accepted, no IDLE cycle.
REQ-039 rst_n pulsed low mid-SHIFT (amt 7) -> state IDLE asynchronously, out_valid never asserted for that request.
